// File: rtl/seq_mul16.sv
// Multi-cycle 16x16 unsigned shift-and-add multiplier (32-bit product) built around one Add32.
// Define MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
//
// state  | meaning
// IDLE   | waiting for start; product holds the last result
// RUN    | one multiplier bit consumed per clock
// DONE   | product valid, done pulses for this single cycle

module add32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c0_i,
    output logic [31:0] sum_o
);
    // The carry out is never needed: the accumulator cannot exceed 32'hFFFE0001.
    assign sum_o = a_i + b_i + {31'b0, c0_i};
endmodule

module seq_mul16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2*WIDTH-1:0] add_sum;
    logic [2*WIDTH-1:0] step_sum;

    add32 u_add32 (
        .a_i   (acc_q),
        .b_i   (mcand_q),
        .c0_i  (1'b0),
        .sum_o (add_sum)
    );

    assign step_sum = mplier_q[0] ? add_sum : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
`ifdef MUL_EARLY_TERM_EN
                if (mplier_q == '0) begin
                    product_d = acc_q;
                    state_d   = S_DONE;
                end else
`endif
                begin
                    acc_d    = step_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        product_d = step_sum;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        product = product_q;
    end
endmodule

// File: tb/tb_seq_mul16.sv
// Directed testbench for seq_mul16 (default build: fixed 17-cycle latency).
module tb_seq_mul16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks = 0;
    int failures = 0;

    seq_mul16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Launches one multiply and returns product, edges from the start-sampling edge
    // to the edge that raised done (inclusive), and the number of busy cycles seen.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          output logic [31:0] p, output int lat,
                          output int busy_cnt, output bit to);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        lat = 0; busy_cnt = 0; to = 1'b1; p = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                to = 1'b0;
                p = product;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, product} !== 34'b0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b product=%h want 0 0 0", busy, done, product);
        end
    endtask

    task automatic test_basic();
        logic [31:0] p; int lat, bc; bit to;
        run_op(16'd3, 16'd5, p, lat, bc, to);
        checks++;
        if (to || p !== 32'h0000000F) begin
            failures++;
            $display("FAIL basic_product got=%h timeout=%0d want 0000000f", p, to);
        end
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL basic_latency got=%0d want 17", lat);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_width done=%b busy=%b want 0 0", done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (product !== 32'h0000000F) begin
            failures++;
            $display("FAIL basic_hold got=%h want 0000000f", product);
        end
    endtask

    task automatic test_max();
        logic [31:0] p; int lat, bc; bit to;
        run_op(16'hFFFF, 16'hFFFF, p, lat, bc, to);
        checks++;
        if (to || p !== 32'hFFFE0001) begin
            failures++;
            $display("FAIL max_product got=%h want fffe0001", p);
        end
        checks++;
        if (bc !== 16) begin
            failures++;
            $display("FAIL max_busy_cycles got=%0d want 16", bc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL max_done_width done=%b want 0", done);
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] p; int lat; bit seen;
        @(negedge clk);
        a = 16'd100; b = 16'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 16'd7; b = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        seen = 1'b0; lat = 7; p = '0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin seen = 1'b1; p = product; break; end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!seen || p !== 32'd20000) begin
            failures++;
            $display("FAIL ignore_product got=%0d seen=%0d want 20000", p, seen);
        end
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL ignore_latency got=%0d want 17", lat);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_not_queued busy=%b done=%b want 0 0", busy, done);
        end
        begin
            logic [31:0] p2; int l2, bc; bit to;
            run_op(16'd7, 16'd7, p2, l2, bc, to);
            checks++;
            if (to || p2 !== 32'd49) begin
                failures++;
                $display("FAIL ignore_next_start got=%0d want 49", p2);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] p; int lat, bc; bit to; bit spurious;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, product} !== 34'b0) begin
            failures++;
            $display("FAIL abort_outputs busy=%b done=%b product=%h want 0 0 0", busy, done, product);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            failures++;
            $display("FAIL abort_no_done spurious=%0d want 0", spurious);
        end
        run_op(16'd2, 16'd9, p, lat, bc, to);
        checks++;
        if (to || p !== 32'd18) begin
            failures++;
            $display("FAIL abort_restart got=%0d want 18", p);
        end
    endtask

    typedef struct { logic [15:0] av; logic [15:0] bv; logic [31:0] exp; } vec_t;

    task automatic test_vectors();
        vec_t vecs[6];
        logic [31:0] p; int lat, bc; bit to;
        vecs[0] = '{16'h1234, 16'h5678, 32'h06260060};
        vecs[1] = '{16'h0000, 16'hABCD, 32'h00000000};
        vecs[2] = '{16'hABCD, 16'h0001, 32'h0000ABCD};
        vecs[3] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[4] = '{16'hFFFF, 16'h0002, 32'h0001FFFE};
        vecs[5] = '{16'h0001, 16'h0000, 32'h00000000};
        foreach (vecs[i]) begin
            run_op(vecs[i].av, vecs[i].bv, p, lat, bc, to);
            checks++;
            if (to || p !== vecs[i].exp || lat !== 17) begin
                failures++;
                $display("FAIL vector_%0d got=%h lat=%0d want %h lat=17", i, p, lat, vecs[i].exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] p, exp; int lat, bc; bit to;
        logic [15:0] av, bv;
        for (int i = 0; i < 1000; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            exp = {16'b0, av} * {16'b0, bv};
            run_op(av, bv, p, lat, bc, to);
            checks++;
            if (to || p !== exp) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h got=%h want %h", i, av, bv, p, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_ignore_start();
        test_reset_abort();
        test_vectors();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
